// File: rtl/mmu_accum_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mmu_accum_ctrl
// Description : Job sequencer for the 12x7 accumulating matrix-multiply unit.
//               Accepts a beat-count descriptor, flushes the MMU accumulation
//               buffers, gates operand beats into the array (bias on the
//               first beat only) and presents the finished sum through a
//               valid/ready handshake.
// Options     : MMU_CTRL_STALL_CNT_EN - when defined, stall_cnt counts ACCUM
//               cycles without an operand beat (saturating). When undefined,
//               stall_cnt is tied to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module mmu_accum_ctrl #(
    parameter int BEAT_W  = 8,
    parameter int STALL_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    // job descriptor
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [BEAT_W-1:0]  cfg_beats,
    output logic               cfg_err,
    // operand/weight beat stream
    input  logic               in_valid,
    output logic               in_ready,
    // MMU datapath controls
    output logic               mmu_flush,
    output logic               mmu_in_en,
    output logic               mmu_bias_en,
    // result handshake
    output logic               res_valid,
    input  logic               res_ready,
    // status
    output logic               busy,
    output logic [STALL_W-1:0] stall_cnt
);

    // ------------------------------------------------------------------------
    // Constants and state encoding
    // ------------------------------------------------------------------------
    localparam logic [BEAT_W-1:0] c_beat_zero = '0;
    localparam logic [BEAT_W-1:0] c_beat_one  = {{(BEAT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CLEAR  = 2'd1,
        ST_ACCUM  = 2'd2,
        ST_RESULT = 2'd3
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [BEAT_W-1:0]   beat_cnt_q;
    logic [BEAT_W-1:0]   beat_cnt_d;
    logic [BEAT_W-1:0]   beats_tgt_q;
    logic [BEAT_W-1:0]   beats_tgt_d;

    // A descriptor with a non-zero length is taken this cycle (IDLE, or the
    // RESULT handshake cycle for back-to-back jobs).
    logic                cfg_take;
    // An operand beat is consumed this cycle.
    logic                beat_take;
    // The consumed beat is the final beat of the job.
    logic                last_beat;
    logic                cfg_len_ok;

    assign cfg_len_ok = (cfg_beats != c_beat_zero);
    assign last_beat  = (beat_cnt_q == (beats_tgt_q - c_beat_one));

    // ------------------------------------------------------------------------
    // State register and job bookkeeping
    // ------------------------------------------------------------------------
    // Sequencer state, beat counter and latched job length.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            beat_cnt_q  <= '0;
            beats_tgt_q <= '0;
        end else begin
            state_q     <= state_d;
            beat_cnt_q  <= beat_cnt_d;
            beats_tgt_q <= beats_tgt_d;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and output decode
    // ------------------------------------------------------------------------
    // All handshake and gate outputs are decoded combinationally from the
    // current state so the operand gate follows in_valid in the same cycle.
    always_comb begin
        state_d     = state_q;
        cfg_ready   = 1'b0;
        cfg_err     = 1'b0;
        cfg_take    = 1'b0;
        in_ready    = 1'b0;
        beat_take   = 1'b0;
        mmu_flush   = 1'b0;
        mmu_in_en   = 1'b0;
        mmu_bias_en = 1'b0;
        res_valid   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cfg_ready = 1'b1;
                if (cfg_valid) begin
                    if (cfg_len_ok) begin
                        cfg_take = 1'b1;
                        state_d  = ST_CLEAR;
                    end else begin
                        cfg_err  = 1'b1;
                    end
                end
            end

            ST_CLEAR: begin
                // One-cycle flush so the first job after reset also starts
                // from cleared buffers.
                mmu_flush = 1'b1;
                state_d   = ST_ACCUM;
            end

            ST_ACCUM: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    beat_take   = 1'b1;
                    mmu_in_en   = 1'b1;
                    // Bias enters the sum exactly once, with the first beat.
                    mmu_bias_en = (beat_cnt_q == c_beat_zero);
                    if (last_beat) begin
                        state_d = ST_RESULT;
                    end
                end
            end

            ST_RESULT: begin
                // Gates stay closed so the buffers hold the finished sum.
                res_valid = 1'b1;
                cfg_ready = res_ready;
                if (res_ready) begin
                    state_d = ST_IDLE;
                    if (cfg_valid) begin
                        if (cfg_len_ok) begin
                            cfg_take = 1'b1;
                            state_d  = ST_CLEAR;
                        end else begin
                            cfg_err  = 1'b1;
                        end
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Beat counter restarts on every accepted job; job length is latched at
    // the same moment. The counter stops at beats_tgt, so it never wraps.
    always_comb begin
        beat_cnt_d  = beat_cnt_q;
        beats_tgt_d = beats_tgt_q;
        if (cfg_take) begin
            beat_cnt_d  = c_beat_zero;
            beats_tgt_d = cfg_beats;
        end else if (beat_take) begin
            beat_cnt_d  = beat_cnt_q + c_beat_one;
        end
    end

    assign busy = (state_q != ST_IDLE);

    // ------------------------------------------------------------------------
    // Optional stall counter
    // ------------------------------------------------------------------------
`ifdef MMU_CTRL_STALL_CNT_EN
    localparam logic [STALL_W-1:0] c_stall_one = {{(STALL_W-1){1'b0}}, 1'b1};
    localparam logic [STALL_W-1:0] c_stall_max = '1;

    logic [STALL_W-1:0] stall_cnt_q;
    logic [STALL_W-1:0] stall_cnt_d;

    // Count ACCUM cycles starved of operands; clear on each new job and hold
    // through RESULT and IDLE so software can read the last job's figure.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (cfg_take) begin
            stall_cnt_d = '0;
        end else if ((state_q == ST_ACCUM) && !in_valid
                     && (stall_cnt_q != c_stall_max)) begin
            stall_cnt_d = stall_cnt_q + c_stall_one;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = '0;
`endif

endmodule
`default_nettype wire
